xu0_strcnt_seq: RTL and testbench
=================================

// Module: xu0_strcnt_seq
// PURPOSE
//  String-count beat sequencer for lswx/stswx. Consumes the XER string byte count
//  (XER[57:63]), the byte count that the leftmost-zero-byte logic produces, and
//  splits the op into 4-byte GPR beats toward the LSU.
//  Each beat carries the effective address, big-endian byte enables and the target GPR.
//  Sits in XU0 between decode/issue and the LSU request port.
// PARAMETERS
//  EA_WIDTH   64  effective-address width; EA bits are [64-EA_WIDTH:63]
//  CNT_WIDTH  7   byte-count width; matches XER[57:63], max 127
// PORTS
//  clk             in   1          core clock
//  rst             in   1          asynchronous reset, active-high
//  dec_seq_val     in   1          start request
//  seq_dec_rdy     out  1          sequencer idle; start accepted when val&rdy
//  dec_seq_cnt     in   CNT_WIDTH  byte count (XER[57:63])
//  dec_seq_ea      in   EA_WIDTH   starting effective address
//  dec_seq_rt      in   5          first GPR (RT for load, RS for store)
//  dec_seq_st      in   1          1=store (stswx), 0=load (lswx)
//  dec_seq_flush   in   1          abort in-flight op
//  seq_lsu_val     out  1          beat valid
//  lsu_seq_rdy     in   1          LSU accepts beat when val&rdy
//  seq_lsu_ea      out  EA_WIDTH   beat address
//  seq_lsu_be      out  4          byte enables [0:3]; byte 0 = leftmost/MSB
//  seq_lsu_gpr     out  5          beat GPR
//  seq_lsu_st      out  1          store/load flag of op
//  seq_lsu_last    out  1          final beat of op
//  seq_dec_done    out  1          one-cycle completion pulse
// BEHAVIOUR
//  - Reset values:
//    - state IDLE; seq_dec_rdy=1.
//    - seq_lsu_val, seq_lsu_last and seq_dec_done are 0.
//    - seq_lsu_ea, seq_lsu_be, seq_lsu_gpr and seq_lsu_st are 0.
//  - FSM states IDLE, ISSUE, DONE; seq_dec_rdy = (state==IDLE).
//  - IDLE:
//    - On dec_seq_val&rdy&~flush, capture cnt, ea, rt and st into rem/ea_q/gpr_q/st_q.
//    - Next state is ISSUE if cnt!=0; DONE if cnt==0 (no beats, zero-length no-op).
//  - ISSUE: seq_lsu_val=1 (registered, first beat the cycle after accept).
//    - nbytes = min(rem,4).
//    - be: left-justified; nbytes 4->1111, 3->1110, 2->1100, 1->1000.
//    - seq_lsu_last = (rem<=4).
//  - Beat transfer on val&rdy:
//    - rem -= nbytes.
//    - ea_q += 4, modulo 2^EA_WIDTH; no alignment check, the LSU handles misalignment.
//    - gpr_q = gpr_q+1 modulo 32 (r31 wraps to r0).
//    - If last, go to DONE.
//  - Stall rule: while val&~rdy, all seq_lsu_* outputs hold stable.
//  - DONE: seq_dec_done=1 for exactly one cycle, then IDLE.
//    - rdy is 0 in DONE, so back-to-back ops have a minimum one-cycle bubble.
//  - Latency:
//    - Accept to first beat is 1 cycle.
//    - Accept to done is N+1 cycles with zero LSU stall, N = ceil(cnt/4); cnt=0 gives 1 cycle.
//  - Beat count is max 32 (cnt=127: 31 full beats plus a final 3-byte beat, be=1110).
//  - Flush:
//    - Any state goes to IDLE next cycle; seq_lsu_val drops and no done pulse is issued.
//    - Flush with start in the same cycle: start is ignored.
//    - Flush with last-beat handshake in the same cycle: beat counts as sent, no done.
//  - Async rst mid-op returns the block to reset values immediately; no done pulse.
// STRUCTURE
//  - Shared package xu_strcnt_pkg holds:
//    - state encoding localparams (IDLE/ISSUE/DONE);
//    - BEAT_BYTES=4;
//    - function strcnt_be(rem) returning the 4-bit left-justified mask.
//  - Single flat module: one FSM plus rem/ea/gpr counters; no sub-module warranted.
// TESTING
//  - cnt=0, ea=0x1000, rt=5: no seq_lsu_val; done 1 cycle after accept; rdy back next.
//  - cnt=10, ea=0x2000, rt=3, rdy=1:
//    - beats (0x2000,1111,r3), (0x2004,1111,r4), (0x2008,1100,r5,last); done next.
//  - cnt=16, rt=30: gpr 30,31,0,1; all be=1111; last on r1.
//  - cnt=127: 32 beats; last be=1110; ea at 0xFFFF_FFFF_FFFF_FFFC then wraps to 0.
//  - cnt=5, LSU rdy low 3 cycles on beat 0: ea/be/gpr held stable; then 1111 and 1000.
//  - Flush after beat 1 of cnt=12: val drops next cycle; no done.
//    - Follow with a new op at cnt=4 (one 1111 beat, done).

Source files
------------

// File: rtl/xu_strcnt_pkg.sv
// Shared definitions for the lswx/stswx string-count beat sequencer.
// State encodings, beat size and the left-justified byte-enable helper.
package xu_strcnt_pkg;

    localparam logic [1:0] STATE_IDLE  = 2'd0;
    localparam logic [1:0] STATE_ISSUE = 2'd1;
    localparam logic [1:0] STATE_DONE  = 2'd2;

    localparam int BEAT_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = STATE_IDLE,
        ISSUE = STATE_ISSUE,
        DONE  = STATE_DONE
    } strcnt_state_e;

    // Byte 0 is the leftmost (most significant) byte of the GPR.
    function automatic logic [0:3] strcnt_be(input int unsigned rem);
        logic [0:3] be;
        case (rem)
            0:       be = 4'b0000;
            1:       be = 4'b1000;
            2:       be = 4'b1100;
            3:       be = 4'b1110;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/xu0_strcnt_seq.sv
// XU0 string-count sequencer: splits an lswx/stswx byte count into 4-byte
// GPR beats (EA, big-endian byte enables, GPR) toward the LSU.
module xu0_strcnt_seq
    import xu_strcnt_pkg::*;
#(
    parameter int EA_WIDTH  = 64,
    parameter int CNT_WIDTH = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     dec_seq_val,
    output logic                     seq_dec_rdy,
    input  logic [CNT_WIDTH-1:0]     dec_seq_cnt,
    input  logic [64-EA_WIDTH:63]    dec_seq_ea,
    input  logic [4:0]               dec_seq_rt,
    input  logic                     dec_seq_st,
    input  logic                     dec_seq_flush,
    output logic                     seq_lsu_val,
    input  logic                     lsu_seq_rdy,
    output logic [64-EA_WIDTH:63]    seq_lsu_ea,
    output logic [0:3]               seq_lsu_be,
    output logic [4:0]               seq_lsu_gpr,
    output logic                     seq_lsu_st,
    output logic                     seq_lsu_last,
    output logic                     seq_dec_done
);

    strcnt_state_e             state, state_d;
    logic [CNT_WIDTH-1:0]      rem;
    logic [64-EA_WIDTH:63]     ea_q;
    logic [4:0]                gpr_q;
    logic                      st_q;

    logic                      accept;
    logic                      xfer;
    logic                      last_beat;
    logic [CNT_WIDTH-1:0]      nbytes;

    assign accept    = (state == IDLE) & dec_seq_val & ~dec_seq_flush;
    assign xfer      = (state == ISSUE) & lsu_seq_rdy;
    assign last_beat = (rem <= CNT_WIDTH'(BEAT_BYTES));
    assign nbytes    = last_beat ? rem : CNT_WIDTH'(BEAT_BYTES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = (dec_seq_cnt == '0) ? DONE : ISSUE;
            ISSUE:   if (lsu_seq_rdy && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Flush wins over everything, including a same-cycle start or last beat.
        if (dec_seq_flush) state_d = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            ea_q  <= '0;
            gpr_q <= '0;
            st_q  <= 1'b0;
        end else if (accept) begin
            rem   <= dec_seq_cnt;
            ea_q  <= dec_seq_ea;
            gpr_q <= dec_seq_rt;
            st_q  <= dec_seq_st;
        end else if (xfer) begin
            // EA and GPR wrap naturally at their widths.
            rem   <= rem - nbytes;
            ea_q  <= ea_q + EA_WIDTH'(BEAT_BYTES);
            gpr_q <= gpr_q + 5'd1;
        end
    end

    assign seq_dec_rdy  = (state == IDLE);
    assign seq_lsu_val  = (state == ISSUE);
    assign seq_lsu_ea   = ea_q;
    assign seq_lsu_gpr  = gpr_q;
    assign seq_lsu_st   = st_q;
    assign seq_lsu_be   = (state == ISSUE) ? strcnt_be(32'(rem)) : 4'b0000;
    assign seq_lsu_last = (state == ISSUE) & last_beat;
    assign seq_dec_done = (state == DONE);

endmodule

// File: tb/tb_xu0_strcnt_seq.sv
// Directed bench for xu0_strcnt_seq: a per-op beat list model checked on every
// beat handshake, plus literal expectations for the documented scenarios.
module tb_xu0_strcnt_seq;

    typedef struct packed {
        logic [63:0] ea;
        logic [3:0]  be;
        logic [4:0]  gpr;
        logic        st;
        logic        last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_seq_val;
    logic        seq_dec_rdy;
    logic [6:0]  dec_seq_cnt;
    logic [0:63] dec_seq_ea;
    logic [4:0]  dec_seq_rt;
    logic        dec_seq_st;
    logic        dec_seq_flush;
    logic        seq_lsu_val;
    logic        lsu_seq_rdy;
    logic [0:63] seq_lsu_ea;
    logic [0:3]  seq_lsu_be;
    logic [4:0]  seq_lsu_gpr;
    logic        seq_lsu_st;
    logic        seq_lsu_last;
    logic        seq_dec_done;

    int vectors = 0;
    int miscompares = 0;

    beat_t exp_q[$];
    beat_t obs[$];
    beat_t held;
    logic  chk_hold = 1'b0;

    xu0_strcnt_seq #(.EA_WIDTH(64), .CNT_WIDTH(7)) dut (
        .clk(clk), .rst(rst),
        .dec_seq_val(dec_seq_val), .seq_dec_rdy(seq_dec_rdy),
        .dec_seq_cnt(dec_seq_cnt), .dec_seq_ea(dec_seq_ea),
        .dec_seq_rt(dec_seq_rt), .dec_seq_st(dec_seq_st),
        .dec_seq_flush(dec_seq_flush),
        .seq_lsu_val(seq_lsu_val), .lsu_seq_rdy(lsu_seq_rdy),
        .seq_lsu_ea(seq_lsu_ea), .seq_lsu_be(seq_lsu_be),
        .seq_lsu_gpr(seq_lsu_gpr), .seq_lsu_st(seq_lsu_st),
        .seq_lsu_last(seq_lsu_last), .seq_dec_done(seq_dec_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic beat_t cur_beat();
        beat_t b;
        b.ea   = seq_lsu_ea;
        b.be   = seq_lsu_be;
        b.gpr  = seq_lsu_gpr;
        b.st   = seq_lsu_st;
        b.last = seq_lsu_last;
        return b;
    endfunction

    // Model: the beat list of an op follows from cnt/ea/rt/st alone.
    task automatic model_op(input int cnt, input logic [63:0] ea, input int rt, input logic st);
        int nb;
        nb = (cnt + 3) / 4;
        for (int i = 0; i < nb; i++) begin
            beat_t b;
            int n;
            n      = (cnt - 4 * i >= 4) ? 4 : cnt - 4 * i;
            b.ea   = ea + 64'(4 * i);
            b.be   = ~(4'hF >> n);
            b.gpr  = 5'((rt + i) % 32);
            b.st   = st;
            b.last = (i == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    // Compare process: every handshake against the model, stalls for stability.
    always @(negedge clk) begin
        if (!rst) begin
            if (chk_hold && seq_lsu_val) check("stall_hold", 128'(cur_beat()), 128'(held));
            chk_hold = 1'b0;
            if (seq_lsu_val) begin
                if (exp_q.size() == 0) begin
                    check("spurious_beat", 128'(cur_beat()), 128'(0));
                end else if (lsu_seq_rdy) begin
                    check("beat", 128'(cur_beat()), 128'(exp_q[0]));
                    void'(exp_q.pop_front());
                    obs.push_back(cur_beat());
                end else begin
                    held     = cur_beat();
                    chk_hold = 1'b1;
                end
            end
        end
    end

    task automatic start_op(input int cnt, input logic [63:0] ea, input int rt, input logic st);
        @(posedge clk); #1;
        check("rdy_before_start", 128'(seq_dec_rdy), 128'(1));
        obs.delete();
        model_op(cnt, ea, rt, st);
        dec_seq_val = 1'b1;
        dec_seq_cnt = 7'(cnt);
        dec_seq_ea  = ea;
        dec_seq_rt  = 5'(rt);
        dec_seq_st  = st;
        @(posedge clk); #1;
        dec_seq_val = 1'b0;
    endtask

    task automatic run_op(input int cnt, input logic [63:0] ea, input int rt,
                          input logic st, input int stall);
        int k;
        int nb;
        nb = (cnt + 3) / 4;
        if (stall > 0) begin
            @(posedge clk); #1;
            lsu_seq_rdy = 1'b0;
        end
        start_op(cnt, ea, rt, st);
        k = 0;
        for (int c = 1; c <= 300; c++) begin
            @(negedge clk);
            if (seq_dec_done) begin
                k = c;
                break;
            end
            if (c == stall) begin
                @(posedge clk); #1;
                lsu_seq_rdy = 1'b1;
            end
        end
        check("done_latency", 128'(k), 128'(nb + 1 + stall));
        check("rdy_low_in_done", 128'(seq_dec_rdy), 128'(0));
        check("beats_left", 128'(exp_q.size()), 128'(0));
        @(negedge clk);
        check("done_one_cycle", 128'(seq_dec_done), 128'(0));
        check("rdy_after_done", 128'(seq_dec_rdy), 128'(1));
        lsu_seq_rdy = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        dec_seq_val = 1'b0; dec_seq_cnt = '0; dec_seq_ea = '0; dec_seq_rt = '0;
        dec_seq_st = 1'b0; dec_seq_flush = 1'b0; lsu_seq_rdy = 1'b1;
        #1;
        check("rst_rdy", 128'(seq_dec_rdy), 128'(1));
        check("rst_outs", 128'({seq_lsu_val, seq_lsu_last, seq_dec_done, seq_lsu_st}), 128'(0));
        check("rst_beat", 128'({seq_lsu_ea, seq_lsu_be, seq_lsu_gpr}), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Zero-length op: no beats, done right away.
        run_op(0, 64'h1000, 5, 1'b0, 0);
        check("cnt0_beats", 128'(obs.size()), 128'(0));

        run_op(10, 64'h2000, 3, 1'b0, 0);
        check("cnt10_n", 128'(obs.size()), 128'(3));
        if (obs.size() == 3) begin
            check("cnt10_b0", 128'(obs[0]), 128'({64'h2000, 4'b1111, 5'd3, 1'b0, 1'b0}));
            check("cnt10_b1", 128'(obs[1]), 128'({64'h2004, 4'b1111, 5'd4, 1'b0, 1'b0}));
            check("cnt10_b2", 128'(obs[2]), 128'({64'h2008, 4'b1100, 5'd5, 1'b0, 1'b1}));
        end

        run_op(16, 64'h3000, 30, 1'b1, 0);
        check("cnt16_n", 128'(obs.size()), 128'(4));
        if (obs.size() == 4) begin
            check("cnt16_gprs", 128'({obs[0].gpr, obs[1].gpr, obs[2].gpr, obs[3].gpr}),
                  128'({5'd30, 5'd31, 5'd0, 5'd1}));
            check("cnt16_last", 128'({obs[3].be, obs[3].last, obs[2].last, obs[3].st}),
                  128'({4'b1111, 1'b1, 1'b0, 1'b1}));
        end

        run_op(127, 64'hFFFF_FFFF_FFFF_FFC0, 0, 1'b0, 0);
        check("cnt127_n", 128'(obs.size()), 128'(32));
        if (obs.size() == 32) begin
            check("cnt127_last_be", 128'({obs[31].be, obs[31].last}), 128'({4'b1110, 1'b1}));
            check("cnt127_ea_top", 128'(obs[15].ea), 128'(64'hFFFF_FFFF_FFFF_FFFC));
            check("cnt127_ea_wrap", 128'(obs[16].ea), 128'(64'h0));
        end

        run_op(5, 64'h4000, 7, 1'b1, 3);
        check("cnt5_n", 128'(obs.size()), 128'(2));
        if (obs.size() == 2)
            check("cnt5_be", 128'({obs[0].be, obs[1].be}), 128'({4'b1111, 4'b1000}));

        // Flush after beat 1 of a 12-byte op; beat 2 handshakes with the flush.
        start_op(12, 64'h5000, 10, 1'b0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        dec_seq_flush = 1'b1;
        @(posedge clk); #1;
        dec_seq_flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("flush_no_val", 128'(seq_lsu_val), 128'(0));
            check("flush_no_done", 128'(seq_dec_done), 128'(0));
        end
        check("flush_rdy", 128'(seq_dec_rdy), 128'(1));
        exp_q.delete();
        run_op(4, 64'h6000, 2, 1'b0, 0);
        if (obs.size() == 1)
            check("post_flush_b0", 128'(obs[0]), 128'({64'h6000, 4'b1111, 5'd2, 1'b0, 1'b1}));
        else
            check("post_flush_n", 128'(obs.size()), 128'(1));

        // Start together with flush is ignored.
        @(posedge clk); #1;
        dec_seq_val = 1'b1; dec_seq_flush = 1'b1; dec_seq_cnt = 7'd8;
        @(posedge clk); #1;
        dec_seq_val = 1'b0; dec_seq_flush = 1'b0;
        @(negedge clk);
        check("flush_start_ign", 128'({seq_dec_rdy, seq_lsu_val}), 128'({1'b1, 1'b0}));
        @(negedge clk);
        check("flush_start_nodone", 128'(seq_dec_done), 128'(0));

        // Async reset mid-op.
        start_op(20, 64'h7000, 1, 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_outs", 128'({seq_dec_rdy, seq_lsu_val, seq_lsu_last, seq_dec_done, seq_lsu_st}),
              128'({1'b1, 4'b0}));
        check("midrst_beat", 128'({seq_lsu_ea, seq_lsu_be, seq_lsu_gpr}), 128'(0));
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_nodone", 128'({seq_dec_done, seq_lsu_val}), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
